// File: rtl/prime_pkg.sv
// Shared definitions for the sequential primality tester.
package prime_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prime_rem_unit.sv
// Combinational remainder of dividend by divisor; a zero divisor yields zero.
module prime_rem_unit #(
  parameter int unsigned WIDTH = prime_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder
);

  assign remainder = (divisor == '0) ? '0 : (dividend % divisor);

endmodule

// File: rtl/prime_seq_ctrl.sv
// Sequential trial-division primality tester: one divisor per cycle,
// early exit on the first factor, last divisor is floor(num/2).
module prime_seq_ctrl
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             ready,
  output logic             done,
  output logic             prime,
  output logic             even,
  output logic [WIDTH-1:0] tested
);

  state_t           r_state;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_cnt;

  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_rem;
  logic             w_small_prime;

  assign w_half        = r_num >> 1;
  assign w_small_prime = (num[WIDTH-1:2] == '0) && num[1];

  prime_rem_unit #(.WIDTH(WIDTH)) u_rem (
    .dividend  (r_num),
    .divisor   (r_d),
    .remainder (w_rem)
  );

  // Control FSM; results are only updated on entry to DONE so they stay stable while CHECK runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_num   <= '0;
      r_d     <= WIDTH'(2);
      r_cnt   <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      prime   <= 1'b0;
      even    <= 1'b0;
      tested  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_num <= num;
            r_d   <= WIDTH'(2);
            r_cnt <= '0;
            ready <= 1'b0;
            if (num < WIDTH'(4)) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              prime   <= w_small_prime;
              even    <= ~num[0];
              tested  <= '0;
            end else begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          r_cnt <= r_cnt + WIDTH'(1);
          if ((w_rem == '0) || (r_d == w_half)) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
            prime   <= (w_rem != '0);
            even    <= ~r_num[0];
            tested  <= r_cnt + WIDTH'(1);
          end else begin
            r_d <= r_d + WIDTH'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          ready   <= 1'b1;
          done    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          ready   <= 1'b1;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
